// File: rtl/chunked_compare_unit_if.sv
// Operand/result bundle between the controller (master) and the chunked compare unit (slave).
// Results stay in place until the next compare completes.
interface chunked_compare_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [2:0]       cond;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] comp;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             cond_true;

  modport master (
    output start, signed_mode, cond, i1, i2,
    input  busy, done, comp, flag_z, flag_n, flag_c, flag_v, cond_true
  );

  modport slave (
    input  start, signed_mode, cond, i1, i2,
    output busy, done, comp, flag_z, flag_n, flag_c, flag_v, cond_true
  );
endinterface

// File: rtl/chunked_compare_unit.sv
// Multi-cycle i1-i2 compare, CHUNK bits per negedge with rippled borrow; done pulses NCH edges after accept.
// No backpressure: start is taken only while idle and ignored while busy.
module chunked_compare_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  chunked_compare_unit_if.slave bus
);
  localparam int NCH  = WIDTH / CHUNK;
  localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [2:0]        cond_q, cond_d;
  logic              signed_q, signed_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [WIDTH-1:0]  comp_q, comp_d;
  logic              z_q, z_d;
  logic              n_q, n_d;
  logic              c_q, c_d;
  logic              v_q, v_d;
  logic              cond_true_q, cond_true_d;
  logic              done_q, done_d;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK:0]    sub;
  logic [WIDTH-1:0]  diff_full;
  logic              last_chunk;
  logic              z_new, n_new, c_new, v_new;
  int                idx;

  function automatic logic eval_cond(input logic [2:0] sel, input logic sgn,
                                     input logic z, input logic n,
                                     input logic c, input logic v);
    logic lt;
    logic res;
    lt  = sgn ? (n ^ v) : c;
    res = 1'b0;
    case (sel)
      3'b000:  res = z;
      3'b001:  res = !z;
      3'b010:  res = lt;
      3'b011:  res = !lt;
      3'b100:  res = !lt && !z;
      3'b101:  res = lt || z;
      3'b110:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Datapath for the chunk selected by cnt_q; diff_full is the shadow with this chunk merged in.
  always_comb begin
    idx        = int'(cnt_q) * CHUNK;
    a_chunk    = a_q[idx +: CHUNK];
    b_chunk    = b_q[idx +: CHUNK];
    sub        = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
    diff_full  = shadow_q;
    diff_full[idx +: CHUNK] = sub[CHUNK-1:0];
    last_chunk = (cnt_q == CNTW'(NCH - 1));
    z_new      = (diff_full == '0);
    n_new      = diff_full[WIDTH-1];
    c_new      = sub[CHUNK];
    v_new      = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_full[WIDTH-1]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    borrow_d    = borrow_q;
    a_d         = a_q;
    b_d         = b_q;
    cond_d      = cond_q;
    signed_d    = signed_q;
    shadow_d    = shadow_q;
    comp_d      = comp_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    v_d         = v_q;
    cond_true_d = cond_true_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.i1;
          b_d      = bus.i2;
          cond_d   = bus.cond;
          signed_d = bus.signed_mode;
          cnt_d    = '0;
          borrow_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        shadow_d = diff_full;
        borrow_d = sub[CHUNK];
        cnt_d    = cnt_q + CNTW'(1);
        if (last_chunk) begin
          cnt_d       = '0;
          comp_d      = diff_full;
          z_d         = z_new;
          n_d         = n_new;
          c_d         = c_new;
          v_d         = v_new;
          cond_true_d = eval_cond(cond_q, signed_q, z_new, n_new, c_new, v_new);
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cond_q      <= '0;
      signed_q    <= 1'b0;
      shadow_q    <= '0;
      comp_q      <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      cond_true_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cond_q      <= cond_d;
      signed_q    <= signed_d;
      shadow_q    <= shadow_d;
      comp_q      <= comp_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      v_q         <= v_d;
      cond_true_q <= cond_true_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.comp      = comp_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;
  assign bus.cond_true = cond_true_q;
endmodule
